// File: rtl/spi_pwm_bank.sv
// spi_pwm_bank: SPI-controlled bank of NUM_CH PWM channels.
//
// A 16-bit SPI mode-0 frame (bit 15 = write, 14:8 address, 7:0 data) sets
// per-channel output/PWM enables, a shared prescaler and per-channel duty
// cycles. Duty values are shadowed and only take effect at the period wrap,
// so an update never truncates a running period.
//
// Build option: define SPI_PWM_READBACK_EN to return the addressed register
// on cipo during read frames; otherwise cipo is tied low and no read path
// is built.
//
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset, clears all state
//   sclk  - SPI clock (asynchronous, mode 0)
//   copi  - SPI data in, MSB first
//   ncs   - SPI chip select, active-low
//   cipo  - SPI read data
//   out   - registered channel outputs [NUM_CH-1:0]
module spi_pwm_bank #(
  parameter int NUM_CH  = 16,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic              cipo,
  output logic [NUM_CH-1:0] out
);

  localparam logic [15:0] CH_MASK = 16'((32'd1 << NUM_CH) - 32'd1);

  // [0],[1] form the 2-flop synchroniser; [2] holds the previous
  // synchronised value for edge detection.
  logic [2:0] sclk_sr;
  logic [1:0] copi_sr;
  logic [2:0] ncs_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of the others.
      sclk_sr <= '0;
      copi_sr <= '0;
      ncs_sr  <= 3'b111;  // idle (deselected) so release never fakes an edge
    end else begin
      sclk_sr <= {sclk_sr[1:0], sclk};
      copi_sr <= {copi_sr[0], copi};
      ncs_sr  <= {ncs_sr[1:0], ncs};
    end
  end

  logic copi_s, ncs_low, sclk_rise, ncs_rise, ncs_fall;
  assign copi_s    = copi_sr[1];
  assign ncs_low   = ~ncs_sr[1];
  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  assign ncs_rise  = ncs_sr[1] & ~ncs_sr[2];
  assign ncs_fall  = ~ncs_sr[1] & ncs_sr[2];

  // Frame capture. The bit counter saturates at 17 so that any over-long
  // frame stays distinguishable from a 16-bit one.
  logic [15:0] shift;
  logic [4:0]  bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (ncs_fall) begin
      bit_cnt <= '0;
    end else if (sclk_rise && ncs_low) begin
      shift <= {shift[14:0], copi_s};
      if (bit_cnt <= 5'd16) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  logic       wr_en, presc_wr;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  assign wr_en    = ncs_rise && (bit_cnt == 5'd16) && shift[15];
  assign wr_addr  = shift[14:8];
  assign wr_data  = shift[7:0];
  assign presc_wr = wr_en && (wr_addr == 7'h04);

  // Register file
  logic [15:0]        out_en, pwm_en;
  logic [PRESC_W-1:0] presc;
  logic [7:0]         duty   [NUM_CH];
  logic [7:0]         shadow [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en <= '0;
      pwm_en <= '0;
      presc  <= '0;
      // NOTE: the duty array is reset element by element because its reset
      // value is architecturally visible via read-back and the PWM outputs.
      for (int i = 0; i < NUM_CH; i++) duty[i] <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        7'h00: out_en[7:0]  <= wr_data & CH_MASK[7:0];
        7'h01: out_en[15:8] <= wr_data & CH_MASK[15:8];
        7'h02: pwm_en[7:0]  <= wr_data & CH_MASK[7:0];
        7'h03: pwm_en[15:8] <= wr_data & CH_MASK[15:8];
        7'h04: presc        <= wr_data[PRESC_W-1:0];
        default: begin
          if (wr_addr[6:4] == 3'b001 && int'(wr_addr[3:0]) < NUM_CH)
            duty[wr_addr[3:0]] <= wr_data;
        end
      endcase
    end
  end

  // Prescaler, period counter and duty shadows
  logic [PRESC_W-1:0] presc_cnt;
  logic [7:0]         per_cnt;
  logic               tick;
  assign tick = (presc_cnt == presc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      per_cnt   <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      if (presc_wr || tick) presc_cnt <= '0;
      else                  presc_cnt <= presc_cnt + 1'b1;

      if (tick) begin
        if (per_cnt == 8'd254) begin
          per_cnt <= '0;
          for (int i = 0; i < NUM_CH; i++) shadow[i] <= duty[i];
        end else begin
          per_cnt <= per_cnt + 8'd1;
        end
      end
    end
  end

  // Compare: shadow 0x00 never wins, 0xFF always wins (per_cnt tops at 254).
  logic [NUM_CH-1:0] pwm;
  always_comb begin
    // NOTE: a default assignment first keeps this block free of latches.
    pwm = '0;
    for (int i = 0; i < NUM_CH; i++) pwm[i] = (per_cnt < shadow[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else        out <= out_en[NUM_CH-1:0] & (~pwm_en[NUM_CH-1:0] | pwm);
  end

`ifdef SPI_PWM_READBACK_EN
  // Read path: the address is complete on the 8th rising edge (7 bits in
  // shift plus the bit arriving now); data leaves on falling edges 8..15.
  logic       sclk_fall;
  logic [6:0] rd_addr;
  logic [7:0] rd_mux, rd_shift;
  assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
  assign rd_addr   = {shift[5:0], copi_s};

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      7'h00: rd_mux = out_en[7:0];
      7'h01: rd_mux = out_en[15:8];
      7'h02: rd_mux = pwm_en[7:0];
      7'h03: rd_mux = pwm_en[15:8];
      7'h04: rd_mux = 8'(presc);
      default: begin
        if (rd_addr[6:4] == 3'b001 && int'(rd_addr[3:0]) < NUM_CH)
          rd_mux = duty[rd_addr[3:0]];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_shift <= '0;
      cipo     <= 1'b0;
    end else if (!ncs_low || ncs_fall) begin
      rd_shift <= '0;
      cipo     <= 1'b0;
    end else if (sclk_rise && bit_cnt == 5'd7) begin
      rd_shift <= shift[6] ? 8'h00 : rd_mux;  // write frames shift zeros
    end else if (sclk_fall) begin
      if (bit_cnt >= 5'd8 && bit_cnt <= 5'd15) begin
        cipo     <= rd_shift[7];
        rd_shift <= {rd_shift[6:0], 1'b0};
      end else begin
        cipo <= 1'b0;
      end
    end
  end
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pwm_bank.sv
// Self-checking bench for spi_pwm_bank: register write/read table, bad
// frames, PWM duty counts, duty shadowing and reset in mid-frame.
module tb_spi_pwm_bank;
  localparam int NUM_CH = 16;
  localparam int HALF   = 5;  // sclk half period in clk cycles
`ifdef SPI_PWM_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sclk = 1'b0;
  logic              copi = 1'b0;
  logic              ncs = 1'b1;
  logic              cipo;
  logic [NUM_CH-1:0] out;

  int total = 0;
  int bad   = 0;

  spi_pwm_bank #(.NUM_CH(NUM_CH), .PRESC_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sclk (sclk),
    .copi (copi),
    .ncs  (ncs),
    .cipo (cipo),
    .out  (out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends nbits of word (zeros past bit 16); cap holds cipo sampled just
  // before each of the first 16 rising edges, MSB first.
  task automatic spi_frame(input logic [15:0] word, input int nbits, output logic [15:0] cap);
    logic b;
    cap = '0;
    ncs = 1'b0;
    idle(HALF);
    for (int i = 0; i < nbits; i++) begin
      b = 1'b0;
      if (i < 16) b = word[15-i];
      copi = b;
      idle(HALF);
      if (i < 16) cap[15-i] = cipo;
      sclk = 1'b1;
      idle(HALF);
      sclk = 1'b0;
    end
    idle(HALF);
    ncs = 1'b1;
    idle(5);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    logic [15:0] cap;
    spi_frame({1'b1, a, d}, 16, cap);
  endtask

  task automatic rd(input logic [6:0] a, output logic [15:0] cap);
    spi_frame({1'b0, a, 8'h00}, 16, cap);
  endtask

  task automatic wait_rise(input int idx, input int budget, output bit ok);
    logic prev;
    ok   = 1'b0;
    prev = out[idx];
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (out[idx] && !prev) ok = 1'b1;
      prev = out[idx];
    end
  endtask

  // Counts high samples of out[idx] over n cycles, starting with the
  // current sample.
  task automatic count_high(input int idx, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (out[idx]) cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    bit          wr;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp_out;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t       vecs[16];
  logic [6:0] rst_addrs[21];

  initial begin
    logic [15:0] cap;
    bit          ok;
    int          c1, c2;

    vecs[0]  = '{1'b1, 7'h00, 8'hFF, 16'h00FF, 8'h00};
    vecs[1]  = '{1'b1, 7'h01, 8'h01, 16'h01FF, 8'h00};
    vecs[2]  = '{1'b0, 7'h00, 8'h00, 16'h01FF, 8'hFF};
    vecs[3]  = '{1'b0, 7'h01, 8'h00, 16'h01FF, 8'h01};
    vecs[4]  = '{1'b1, 7'h7F, 8'hAA, 16'h01FF, 8'h00};
    vecs[5]  = '{1'b0, 7'h7F, 8'h00, 16'h01FF, 8'h00};
    vecs[6]  = '{1'b1, 7'h15, 8'hA5, 16'h01FF, 8'h00};
    vecs[7]  = '{1'b0, 7'h15, 8'h00, 16'h01FF, 8'hA5};
    vecs[8]  = '{1'b1, 7'h04, 8'h03, 16'h01FF, 8'h00};
    vecs[9]  = '{1'b0, 7'h04, 8'h00, 16'h01FF, 8'h03};
    vecs[10] = '{1'b1, 7'h20, 8'h55, 16'h01FF, 8'h00};
    vecs[11] = '{1'b0, 7'h20, 8'h00, 16'h01FF, 8'h00};
    vecs[12] = '{1'b1, 7'h01, 8'h80, 16'h80FF, 8'h00};
    vecs[13] = '{1'b0, 7'h05, 8'h00, 16'h80FF, 8'h00};
    vecs[14] = '{1'b1, 7'h02, 8'h01, 16'h80FE, 8'h00};  // ch0 PWM, duty 0
    vecs[15] = '{1'b0, 7'h02, 8'h00, 16'h80FE, 8'h01};

    rst_addrs[0] = 7'h00; rst_addrs[1] = 7'h01; rst_addrs[2] = 7'h02;
    rst_addrs[3] = 7'h03; rst_addrs[4] = 7'h04;
    for (int i = 0; i < 16; i++) rst_addrs[5+i] = 7'(7'h10 + i);

    // Reset values
    idle(4);
    check("rst_out_low", 32'(out), 32'h0);
    check("rst_cipo_low", 32'(cipo), 32'h0);
    rst_n = 1'b1;
    idle(3);
    check("rst_out", 32'(out), 32'h0);
    check("rst_cipo", 32'(cipo), 32'h0);
    for (int i = 0; i < 21; i++) begin
      rd(rst_addrs[i], cap);
      check($sformatf("rst_reg_%02h", rst_addrs[i]), 32'(cap), 32'h0);
    end

    // Register table: out checked 5 clk after ncs rise
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].wr) begin
        wr(vecs[i].addr, vecs[i].data);
      end else begin
        rd(vecs[i].addr, cap);
        check($sformatf("vec%0d_rd_%02h", i, vecs[i].addr), 32'(cap),
              32'({8'h00, RB ? vecs[i].exp_rd : 8'h00}));
      end
      check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
    end

    // Bad frames: 15 bits, 17 bits, then a valid frame
    spi_frame(16'h8000, 15, cap);
    check("short_out", 32'(out), 32'h80FE);
    spi_frame(16'hC000, 17, cap);
    check("long_out", 32'(out), 32'h80FE);
    rd(7'h00, cap);
    check("bad_rd_00", 32'(cap), 32'({8'h00, RB ? 8'hFF : 8'h00}));
    wr(7'h00, 8'h0F);
    check("valid_after_bad", 32'(out), 32'h800E);

    // PWM duty on channel 3, presc 0 (255-cycle period)
    wr(7'h00, 8'h08); wr(7'h01, 8'h00);
    wr(7'h02, 8'h08); wr(7'h03, 8'h00);
    wr(7'h04, 8'h00); wr(7'h13, 8'h80);
    wait_rise(3, 600, ok);
    check("duty80_rise", 32'(ok), 32'h1);
    count_high(3, 255, c1);
    count_high(3, 255, c2);
    check("duty80_p1", 32'(c1), 32'd128);
    check("duty80_p2", 32'(c2), 32'd128);
    wr(7'h13, 8'h00);
    idle(520);
    count_high(3, 255, c1);
    check("duty00", 32'(c1), 32'd0);
    wr(7'h13, 8'hFF);
    idle(520);
    count_high(3, 255, c1);
    check("dutyFF", 32'(c1), 32'd255);

    // Shadowing on channel 0, presc 3 (1020-cycle period)
    wr(7'h04, 8'h03);
    wr(7'h02, 8'h01);
    wr(7'h00, 8'h01);
    wr(7'h10, 8'h40);
    wait_rise(0, 2200, ok);
    check("shadow_rise", 32'(ok), 32'h1);
    fork
      begin
        count_high(0, 1020, c1);
        count_high(0, 1020, c2);
      end
      begin
        idle(20);
        wr(7'h10, 8'hC0);
      end
    join
    check("shadow_cur", 32'(c1), 32'd256);
    check("shadow_next", 32'(c2), 32'd768);

    // Reset in the middle of a write frame
    ncs = 1'b0;
    idle(HALF);
    for (int i = 0; i < 6; i++) begin
      copi = 1'b1;
      idle(HALF);
      sclk = 1'b1;
      idle(HALF);
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    idle(2);
    check("midrst_out", 32'(out), 32'h0);
    check("midrst_cipo", 32'(cipo), 32'h0);
    ncs  = 1'b1;
    copi = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(10);
    check("postrst_out", 32'(out), 32'h0);
    rd(7'h00, cap);
    check("postrst_rd_00", 32'(cap), 32'h0);
    rd(7'h10, cap);
    check("postrst_rd_10", 32'(cap), 32'h0);
    wr(7'h00, 8'h02);
    check("postrst_wr", 32'(out), 32'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_pwm_bank.md
# spi_pwm_bank

Parametrised SPI-controlled PWM bank: the next generation of the onboarding SPI + PWM peripheral, with a configurable channel count, per-channel duty cycles, a programmable prescaler, glitch-free duty updates and optional register read-back over CIPO. It sits directly behind the tile top level. SPI pins come from the dedicated inputs, and `out` drives the dedicated and bidirectional output pins.

## Interface
- `NUM_CH`, 16, number of PWM channels, 1..16.
- `PRESC_W`, 8, prescaler width in bits, 1..8. Reg 0x04 uses bits [PRESC_W-1:0].
- `clk` input 1: system clock, single domain.
- `rst_n` input 1: reset, asynchronous, active-low. All state is cleared while low.
- `sclk` input 1: SPI clock, asynchronous to `clk`, mode 0.
- `copi` input 1: SPI data in, MSB first.
- `ncs` input 1: SPI chip select, active-low.
- `cipo` output 1: SPI read data.
- `out` output NUM_CH: channel outputs.

## Operation
- **Input synchronisation:** `sclk`, `copi` and `ncs` each pass through a 2-flop synchroniser. Edges are detected on the synchronised values.
- **Frame format:** 16 bits, captured on `sclk` rising edges while `ncs` is low.
  - Bit 15: R/W, where 1 = write.
  - Bits 14:8: address.
  - Bits 7:0: data.
- **Frame commit:** on the `ncs` rising edge, a write commits only if exactly 16 bits were received. Frames with fewer or more bits are discarded with no state change. The bit counter clears on every `ncs` falling edge.
- **Register map** (reset value 0x00 for all):
  - 0x00: `out_en[7:0]`.
  - 0x01: `out_en[15:8]`.
  - 0x02: `pwm_en[7:0]`.
  - 0x03: `pwm_en[15:8]`.
  - 0x04: `presc`.
  - 0x10+i: `duty[i]`, for i < NUM_CH.
- **Invalid accesses:** writes to unmapped addresses, or to channel bits/duty registers at or above NUM_CH, are ignored. Reads of those return 0.
- **Prescaler:** the prescaler counter counts 0..presc, then issues a tick and wraps. A write to 0x04 loads the new value and clears the prescaler counter.
- **Period counter:** advances by one per tick and counts 0..254, then wraps, giving 255 ticks per period.
- **Duty shadowing:** each `duty[i]` has a shadow register. All shadows load from their live registers on the tick where the period counter wraps 254→0, so a new duty never cuts a period short.
- **PWM compare:** `pwm[i]` = 1 when period counter < shadow[i]. Shadow 0x00 gives constant 0. Shadow 0xFF gives constant 1.
- **Output select:**
  - `out[i]` = 0 when `out_en[i]`=0.
  - `out[i]` = 1 when `out_en[i]`=1 and `pwm_en[i]`=0.
  - `out[i]` = `pwm[i]` when `out_en[i]`=1 and `pwm_en[i]`=1.
- **Enable changes:** `out_en`/`pwm_en` take effect immediately and are not shadowed.
- **Outputs are registered.**
- **Reset mid-operation:** aborts any frame, zeroes all registers, shadows and counters, and forces `out`=0 and `cipo`=0.

## Timing
- `sclk` high and low times must each be ≥ 3 `clk` cycles, i.e. f_sclk ≤ f_clk/6.
- Write latency: the register updates at most 4 `clk` cycles after the `ncs` pin rises (2 sync + 1 detect + 1 write).
- `out` reflects a new enable bit 1 cycle after the register updates.
- A new duty value reaches `out` at the next period wrap, up to 255×(presc+1) cycles later.
- Read timing:
  - The address is latched on the 8th `sclk` rising edge.
  - `cipo` shifts out data bits 7..0, changing on synchronised `sclk` falling edges 8..15, and is valid before the master's rising edges 9..16.
  - `cipo` is 0 during bits 15..8 and whenever `ncs` is high.

## Configuration
- `SPI_PWM_READBACK_EN`:
  - **Defined:** read frames (bit 15 = 0) return the addressed register on `cipo` as described above.
  - **Undefined:** `cipo` is tied to 0, read frames are accepted and discarded, and the read-path mux and shift logic are not built.

## Test plan
- **Reset values:** hold `rst_n` low, then release → `out`=0x0000, `cipo`=0, and all registers read back 0x00 (with the macro defined).
- **Static enable:** write 0x00←0xFF and 0x01←0x01, with `pwm_en`=0 → `out`=0x01FF within 5 `clk` cycles of the `ncs` rise.
- **PWM duty:** write `presc`=0, `duty[3]`=0x80, `pwm_en[3]`=1, `out_en[3]`=1 → `out[3]` is high for exactly 128 of every 255 cycles from the next period wrap. Repeat with 0x00 (constant 0) and 0xFF (constant 1).
- **Shadowing:** with `presc`=3, change `duty[0]` 0x40→0xC0 mid-period → the current period still ends with 64 high ticks, and the next period shows 192 high ticks, each tick being 4 cycles.
- **Bad frames:** send a 15-bit frame, a 17-bit frame and a write to address 0x7F → no register changes. Then send a valid frame → it commits normally.
- **Read-back and reset:** write `duty[5`]=0xA5, then read 0x15 → `cipo` shifts 1010_0101 (macro defined) or all 0 (macro undefined). Assert `rst_n` mid-frame → no commit and all outputs are 0.
